// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag register / conditional branch resolution unit.
// Holds flag bit positions, condition codes, ALU opcodes and the FSM state encoding.
package flag_branch_unit_pkg;

   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagV = 1;
   localparam int unsigned FlagN = 0;

   localparam logic [15:0] StallCntMax = 16'hFFFF;

   typedef enum logic [2:0] {
      CondNe     = 3'b000,
      CondEq     = 3'b001,
      CondGt     = 3'b010,
      CondLt     = 3'b011,
      CondGte    = 3'b100,
      CondLte    = 3'b101,
      CondOvfl   = 3'b110,
      CondUncond = 3'b111
   } cond_e;

   typedef enum logic [2:0] {
      AluAdd    = 3'b000,
      AluSub    = 3'b001,
      AluXor    = 3'b010,
      AluRed    = 3'b011,
      AluSll    = 3'b100,
      AluSra    = 3'b101,
      AluRor    = 3'b110,
      AluPaddsb = 3'b111
   } alu_op_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StWait = 1'b1
   } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a branch condition code against a {Z,V,N} flag vector.
module branch_cond_eval
   import flag_branch_unit_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] flags,
   output logic       taken
);

   logic z, v, n;

   assign z = flags[FlagZ];
   assign v = flags[FlagV];
   assign n = flags[FlagN];

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         CondNe:     taken = !z;
         CondEq:     taken = z;
         CondGt:     taken = !z && !n;
         CondLt:     taken = n;
         CondGte:    taken = z || (!z && !n);
         CondLte:    taken = n || z;
         CondOvfl:   taken = v;
         CondUncond: taken = 1'b1;
         default:    taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register plus ID-stage branch resolution; stalls the branch one
// cycle when the EX instruction is still producing the flags it depends on.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic [2:0]  flags_ex,
   input  logic        flags_set_ex,
   input  logic [2:0]  alu_op_ex,
   input  logic        br_valid_id,
   input  logic [2:0]  br_cond_id,
   output logic [2:0]  flags_q,
   output logic        stall,
   output logic        br_resolved,
   output logic        br_taken,
   output logic [15:0] stall_cnt
);

   state_e state_q, state_d;
   logic   stall_q;
   logic   cond_taken;
   logic   full_update;

   branch_cond_eval u_cond_eval (
      .cond  (br_cond_id),
      .flags (flags_q),
      .taken (cond_taken)
   );

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      br_resolved = 1'b0;
      if (rst) begin
         state_d = StIdle;
      end else if (hold) begin
         // Frozen pipeline keeps presenting whatever stall level it was frozen with.
         stall = stall_q;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (br_valid_id) begin
                  if (flags_set_ex) begin
                     stall   = 1'b1;
                     state_d = StWait;
                  end else begin
                     br_resolved = 1'b1;
                  end
               end
            end
            StWait: begin
               if (!br_valid_id) begin
                  state_d = StIdle;
               end else if (flags_set_ex) begin
                  stall = 1'b1;
               end else begin
                  br_resolved = 1'b1;
                  state_d     = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign br_taken    = br_resolved && cond_taken;
   assign full_update = (alu_op_ex == AluAdd) || (alu_op_ex == AluSub);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         stall_q   <= 1'b0;
         flags_q   <= 3'b000;
         stall_cnt <= 16'h0000;
      end else if (!hold) begin
         state_q <= state_d;
         stall_q <= stall;
         if (flags_set_ex) begin
            if (full_update) begin
               flags_q <= flags_ex;
            end else begin
               flags_q[FlagZ] <= flags_ex[FlagZ];
            end
         end
         if (stall && (stall_cnt != StallCntMax)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level model.
module tb_flag_branch_unit;

   logic        clk = 1'b0;
   logic        rst, hold, flags_set_ex, br_valid_id;
   logic [2:0]  flags_ex, alu_op_ex, br_cond_id;
   logic [2:0]  flags_q;
   logic        stall, br_resolved, br_taken;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [2:0] m_flags = 3'b000;
   int         m_cnt = 0;
   logic       m_last_stall = 1'b0;

   logic obs_stall, obs_res, obs_taken;

   always #5 clk = ~clk;

   flag_branch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .hold         (hold),
      .flags_ex     (flags_ex),
      .flags_set_ex (flags_set_ex),
      .alu_op_ex    (alu_op_ex),
      .br_valid_id  (br_valid_id),
      .br_cond_id   (br_cond_id),
      .flags_q      (flags_q),
      .stall        (stall),
      .br_resolved  (br_resolved),
      .br_taken     (br_taken),
      .stall_cnt    (stall_cnt)
   );

   function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
      logic z, v, n;
      z = f[2];
      v = f[1];
      n = f[0];
      case (cc)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || (!z && !n);
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive, check combinational/registered outputs at negedge, advance model.
   task automatic step(input logic r, input logic h, input logic [2:0] fe, input logic fs,
                       input logic [2:0] op, input logic bv, input logic [2:0] cc);
      logic e_stall, e_res, e_tak;
      rst = r; hold = h; flags_ex = fe; flags_set_ex = fs;
      alu_op_ex = op; br_valid_id = bv; br_cond_id = cc;
      @(negedge clk);
      if (r) begin
         e_stall = 1'b0; e_res = 1'b0;
      end else if (h) begin
         e_stall = m_last_stall; e_res = 1'b0;
      end else begin
         // A branch waits exactly while a flag writer sits in EX; otherwise it resolves.
         e_stall = bv && fs; e_res = bv && !fs;
      end
      e_tak = e_res && cond_true(cc, m_flags);
      chk("stall", {15'd0, stall}, {15'd0, e_stall});
      chk("br_resolved", {15'd0, br_resolved}, {15'd0, e_res});
      chk("br_taken", {15'd0, br_taken}, {15'd0, e_tak});
      chk("flags_q", {13'd0, flags_q}, {13'd0, m_flags});
      chk("stall_cnt", stall_cnt, 16'(m_cnt));
      obs_stall = stall; obs_res = br_resolved; obs_taken = br_taken;
      @(posedge clk);
      if (r) begin
         m_flags = 3'b000; m_cnt = 0; m_last_stall = 1'b0;
      end else if (!h) begin
         if (fs) begin
            if (op == 3'd0 || op == 3'd1) m_flags = fe;
            else m_flags[2] = fe[2];
         end
         if (e_stall && m_cnt < 65535) m_cnt++;
         m_last_stall = e_stall;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; flags_ex = '0; flags_set_ex = 1'b0;
      alu_op_ex = '0; br_valid_id = 1'b0; br_cond_id = '0;
      @(posedge clk);
      #1;

      // Reset with hold asserted
      step(1, 1, 3'b111, 1, 3'd0, 1, 3'd7);
      chk("rst_flags", {13'd0, flags_q}, 16'h0000);
      chk("rst_cnt", stall_cnt, 16'h0000);
      step(0, 0, 3'b000, 0, 3'd0, 0, 3'd0);
      chk("post_rst_stall", {15'd0, obs_stall}, 16'h0000);

      // No hazard: flags 100, EQ branch resolves same cycle
      step(0, 0, 3'b100, 1, 3'd0, 0, 3'd0);
      step(0, 0, 3'b000, 0, 3'd2, 1, 3'd1);
      chk("nohaz_res", {15'd0, obs_res}, 16'h0001);
      chk("nohaz_taken", {15'd0, obs_taken}, 16'h0001);

      // Hazard: SUB writes 001 while LT waits in ID
      step(0, 0, 3'b001, 1, 3'd1, 1, 3'd3);
      chk("haz_stall", {15'd0, obs_stall}, 16'h0001);
      step(0, 0, 3'b000, 0, 3'd0, 1, 3'd3);
      chk("haz_taken", {15'd0, obs_taken}, 16'h0001);
      chk("haz_stall_off", {15'd0, obs_stall}, 16'h0000);
      chk("haz_flags", {13'd0, flags_q}, 16'h0001);
      chk("haz_cnt", stall_cnt, 16'h0001);

      // Z-only update by XOR, then OVFL taken
      step(0, 0, 3'b011, 1, 3'd0, 0, 3'd0);
      step(0, 0, 3'b100, 1, 3'd2, 0, 3'd0);
      chk("zonly_flags", {13'd0, flags_q}, 16'h0007);
      step(0, 0, 3'b000, 0, 3'd0, 1, 3'd6);
      chk("ovfl_taken", {15'd0, obs_taken}, 16'h0001);

      // Hold for three cycles while waiting
      step(0, 0, 3'b000, 1, 3'd1, 1, 3'd0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 3'b101, 1, 3'd0, 1, 3'd0);
         chk("hold_res", {15'd0, obs_res}, 16'h0000);
      end
      chk("hold_flags", {13'd0, flags_q}, 16'h0000);
      chk("hold_cnt", stall_cnt, 16'h0002);
      step(0, 0, 3'b000, 0, 3'd0, 1, 3'd0);
      chk("hold_release_res", {15'd0, obs_res}, 16'h0001);
      chk("hold_release_taken", {15'd0, obs_taken}, 16'h0001);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) == 0),
              3'($urandom), ($urandom_range(0, 2) != 0), 3'($urandom),
              ($urandom_range(0, 3) != 0), 3'($urandom));
      end

      // Saturation: continuous back-to-back setters keep the branch stalled
      step(1, 0, 3'b000, 0, 3'd0, 0, 3'd0);
      for (int i = 0; i < 65534; i++) begin
         step(0, 0, 3'b010, 1, 3'd0, 1, 3'd3);
      end
      chk("sat_pre", stall_cnt, 16'hFFFE);
      step(0, 0, 3'b010, 1, 3'd0, 1, 3'd3);
      step(0, 0, 3'b010, 1, 3'd0, 1, 3'd3);
      chk("sat_max", stall_cnt, 16'hFFFF);
      step(0, 0, 3'b010, 1, 3'd0, 1, 3'd3);
      chk("sat_hold", stall_cnt, 16'hFFFF);

      // Reset while waiting abandons the branch
      step(1, 0, 3'b000, 0, 3'd0, 1, 3'd7);
      chk("rst_wait_res", {15'd0, obs_res}, 16'h0000);
      chk("rst_wait_cnt", stall_cnt, 16'h0000);
      step(0, 0, 3'b000, 0, 3'd0, 0, 3'd7);
      chk("rst_wait_idle_res", {15'd0, obs_res}, 16'h0000);
      step(0, 0, 3'b000, 0, 3'd0, 1, 3'd7);
      chk("after_rst_res", {15'd0, obs_res}, 16'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: clk and rst, with rst sampled only on the rising edge of clk.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  global pipeline freeze.
- flags_ex  in  3  {Z,V,N} produced by the EX-stage ALU.
- flags_set_ex  in  1  EX instruction writes flags.
- alu_op_ex  in  3  EX ALU opcode: ADD 000, SUB 001, XOR 010, RED 011, SLL 100, SRA 101, ROR 110, PADDSB 111.
- br_valid_id  in  1  ID stage holds a conditional branch.
- br_cond_id  in  3  branch condition code.
- flags_q  out  3  architectural {Z,V,N} register.
- stall  out  1  freeze IF/ID and insert an EX bubble.
- br_resolved  out  1  branch decision valid this cycle.
- br_taken  out  1  branch taken; meaningful only when br_resolved=1.
- stall_cnt  out  16  saturating count of flag-hazard stall cycles.

Function
REQ-003 The flag register SHALL update on a clock edge only when flags_set_ex=1 and hold=0.
REQ-004 When alu_op_ex[2:1]=00 (ADD/SUB), the update SHALL write all three flags from flags_ex.
REQ-005 For any other opcode, the update SHALL write Z only; V and N SHALL be retained.
REQ-006 The block SHALL implement an FSM with two states, IDLE and WAIT.
REQ-007 In IDLE, when br_valid_id=1, flags_set_ex=0 and hold=0, the block SHALL assert br_resolved=1 combinationally in the same cycle, evaluate the condition on the current flags_q, and remain in IDLE.
REQ-008 In IDLE, when br_valid_id=1, flags_set_ex=1 and hold=0, the block SHALL assert stall=1 and br_resolved=0 and move to WAIT; the flag update of REQ-003 SHALL occur on that same edge.
REQ-009 In WAIT with hold=0 and br_valid_id=1, the block SHALL resolve using the updated flags_q, deassert stall, and return to IDLE.
REQ-010 In WAIT, if flags_set_ex=1 again (back-to-back setter), the block SHALL keep stall=1 and remain in WAIT for one further cycle.
REQ-011 In WAIT, if br_valid_id drops (flush), the block SHALL return to IDLE with br_resolved=0 and stall=0.
REQ-012 While hold=1, the block SHALL freeze the state, flags_q and stall_cnt, force br_resolved=0, and hold stall at its current registered level.
REQ-013 Condition codes SHALL evaluate as follows:
- 000 NE: Z=0.
- 001 EQ: Z=1.
- 010 GT: Z=0 & N=0.
- 011 LT: N=1.
- 100 GTE: Z=1 | (Z=0 & N=0).
- 101 LTE: N=1 | Z=1.
- 110 OVFL: V=1.
- 111 UNCOND: always taken.
REQ-014 stall_cnt SHALL increment on every edge where stall=1 and hold=0, and SHALL saturate at 16'hFFFF with no wrap-around.
REQ-015 br_taken SHALL be 0 whenever br_resolved=0.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL set flags_q=3'b000, state=IDLE and stall_cnt=16'h0000; rst SHALL take priority over hold and all other inputs.
REQ-017 During and immediately after reset, outputs stall, br_resolved and br_taken SHALL be 0.
REQ-018 A reset asserted while in WAIT SHALL abandon the pending branch without resolving it.

Structure
REQ-019 A shared package SHALL hold:
- the condition-code constants;
- the flag bit indices (Z=2, V=1, N=0);
- the ALU opcode constants;
- the FSM state encoding.
REQ-020 Condition evaluation SHALL live in one combinational sub-module, branch_cond_eval (inputs: cond, flags; output: taken).

Verification
REQ-021 Reset: assert rst with hold=1 -> flags_q=000, stall_cnt=0, stall=0.
REQ-022 No hazard: flags_q=100 with EQ branch and flags_set_ex=0 -> br_resolved=1 and br_taken=1 in the same cycle; stall=0.
REQ-023 Hazard: SUB in EX with flags_ex=001 plus LT branch in ID -> stall=1 for exactly one cycle, then br_taken=1, flags_q=001, stall_cnt=1.
REQ-024 Z-only update: flags_q=011, XOR in EX with flags_ex=100 -> flags_q=111; a following OVFL branch is taken.
REQ-025 hold=1 asserted in WAIT for 3 cycles -> state, flags_q and stall_cnt are unchanged and br_resolved=0; the branch resolves on the first cycle after hold is released.
REQ-026 Saturation and reset: preload stall_cnt=16'hFFFE, then two hazard stalls -> stall_cnt=16'hFFFF; rst asserted while in WAIT -> IDLE, no resolve.
